spi_master_mcs: RTL

Parametrised next-generation SPI master. It adds configurable frame width, several chip-selects, and a command FIFO so software can queue back-to-back frames. It sits on the Pclk domain between the register/bus interface and the SPI pads. Frames drain from the FIFO while `enable` is high, each to the chip-select named in its entry.

---
 rtl/spi_master_mcs.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_mcs.sv
// spi_master_mcs: queued multi-chip-select SPI master; SPI_LSB_FIRST_EN adds the lsb_first port.
// Latency: a push into an empty idle block drops cs_n two edges later; CS stays low (2+2*DATA_W)*D cycles.
// Backpressure: none upstream; a push while tx_full is dropped and recorded on sticky tx_ovf.
`timescale 1ns/1ps

// Small generic FIFO: registered pointers, combinational head read, push ignored when full.
module spi_mcs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = in_vld && !full;
  assign do_pop  = out_rdy && !empty;
  assign out_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= in_dat;
  end
endmodule

// spi_master_mcs: pops queued frames and shifts them out on SCLK to the selected chip-select.
// Latency: pop one edge after tx_empty falls; rx_valid pulses as CS deasserts at frame end.
// Backpressure: frames wait in the FIFO while enable is low; overflowing pushes set tx_ovf.
module spi_master_mcs #(
  parameter int DATA_W     = 8,
  parameter int NUM_CS     = 4,
  parameter int DIV_W      = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [1:0]        mode,
  input  logic              enable,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic [CS_W-1:0]   cs_sel,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic              miso,
  output logic [DATA_W-1:0] read_data,
  output logic              rx_valid,
  output logic [NUM_CS-1:0] cs_n,
  output logic              sclk,
  output logic              mosi,
  output logic              pos_edge,
  output logic              neg_edge,
  output logic              busy,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_ovf
);
  localparam int FW   = CS_W + DATA_W;
  localparam int EC_W = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              pop;
  logic [FW-1:0]     fifo_dat;
  logic [DATA_W-1:0] fifo_word;
  logic [CS_W-1:0]   fifo_cs;
  logic [NUM_CS-1:0] cs_dec;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [EC_W-1:0]   edge_cnt;
  logic              cpha_q;
  logic              lsb_in;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              tick;
  logic              last_edge;
  logic              leading;
  logic              sclk_evt;
  logic              sample_evt;
  logic              shift_evt;
  logic              frame_end;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  // Bit currently at the head of the shift order.
  function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  // Advance the transmit register by one bit in the selected order.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  spi_mcs_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Pclk),
    .rst_n   (Preset),
    .in_vld  (write_en),
    .in_dat  ({cs_sel, write_data}),
    .out_rdy (pop),
    .out_dat (fifo_dat),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign fifo_word = fifo_dat[DATA_W-1:0];
  assign fifo_cs   = fifo_dat[FW-1:DATA_W];

  // One-hot select of the head entry; an out-of-range index selects nothing.
  always_comb begin
    cs_dec = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      cs_dec[i] = (fifo_cs == CS_W'(i));
    end
  end

  assign div_eff    = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign tick       = (cnt_q == '0);
  assign last_edge  = (edge_cnt == EC_W'(2 * DATA_W - 1));
  assign leading    = ~edge_cnt[0];
  assign sclk_evt   = (state_q == ST_XFER) && tick;
  assign sample_evt = sclk_evt && (cpha_q ? !leading : leading);
  assign shift_evt  = sclk_evt && (cpha_q ? leading : !leading);
  assign frame_end  = (state_q == ST_HOLD) && tick;
  assign busy       = (state_q != ST_IDLE);

  // State register.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and FIFO pop: one frame per pass through IDLE.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !tx_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && last_edge) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-frame settings are frozen at pop so mid-frame input changes are ignored.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      cpha_q <= 1'b0;
      lsb_q  <= 1'b0;
      div_q  <= DIV_W'(1);
    end else if (pop) begin
      cpha_q <= mode[0];
      lsb_q  <= lsb_in;
      div_q  <= div_eff;
    end
  end

  // Half-period timer and SCLK edge counter; tick marks the end of each D-cycle slot.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      cnt_q    <= '0;
      edge_cnt <= '0;
    end else if (pop) begin
      cnt_q    <= div_eff - DIV_W'(1);
      edge_cnt <= '0;
    end else if (busy) begin
      cnt_q <= tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
      if (sclk_evt) edge_cnt <= edge_cnt + 1'b1;
    end
  end

  // SCLK follows CPOL while idle and toggles once per slot in XFER; edge strobes align with the toggle.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      sclk     <= 1'b0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      if (state_q == ST_IDLE) begin
        sclk <= mode[1];
      end else if (sclk_evt) begin
        sclk     <= ~sclk;
        pos_edge <= ~sclk;
        neg_edge <= sclk;
      end
    end
  end

  // Transmit path: CPHA=0 presents the first bit at pop, CPHA=1 presents each bit on its leading edge.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      tx_sh <= '0;
      mosi  <= 1'b0;
    end else if (pop) begin
      tx_sh <= fifo_word;
      mosi  <= mode[0] ? 1'b0 : head_bit(fifo_word, lsb_in);
    end else if (shift_evt) begin
      tx_sh <= shift_out(tx_sh, lsb_q);
      mosi  <= cpha_q ? head_bit(tx_sh, lsb_q) : head_bit(shift_out(tx_sh, lsb_q), lsb_q);
    end else if (frame_end) begin
      mosi  <= 1'b0;
    end
  end

  // Receive path: the shift direction matches the transmit order so read_data is not reversed.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      rx_sh <= '0;
    end else if (pop) begin
      rx_sh <= '0;
    end else if (sample_evt) begin
      rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
    end
  end

  // Chip-select, result register and rx_valid; CS release and rx_valid share the HOLD exit edge.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      cs_n      <= '1;
      read_data <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (pop) begin
        cs_n <= ~cs_dec;
      end else if (frame_end) begin
        cs_n      <= '1;
        read_data <= rx_sh;
        rx_valid  <= 1'b1;
      end
    end
  end

  // Sticky drop flag: a push while full is lost even if a pop frees a slot that cycle.
  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset)                   tx_ovf <= 1'b0;
    else if (write_en && tx_full)  tx_ovf <= 1'b1;
  end
endmodule
